haze_recover_pipe: RTL

HAZE_RECOVER_PIPE -- requirements
Module: haze_recover_pipe

---
 rtl/haze_recover_pipe_if.sv | 42 ++++
 rtl/haze_recover_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/haze_recover_pipe_if.sv
// Pixel-stream bundle for haze_recover_pipe.
// Ports:
//   pre_frame_vsync/href/clken : input timing, pixel valid when clken=1
//   pre_img    [CH*DW]         : hazy pixel, channel 0 in the LSB field
//   pre_tx_img [DW]            : transmission code aligned with pre_img
//   pre_A      [CH*DW]         : per-channel atmospheric light
//   bypass                     : 1 = forward pre_img unmodified
//   post_frame_vsync/href/clken: input timing delayed by the pipe latency
//   post_img   [CH*DW]         : recovered pixel
//   frame_sat_cnt [CW]         : saturated-pixel count of the last frame
interface haze_recover_pipe_if #(
    parameter int DW = 8,
    parameter int CH = 3,
    parameter int CW = 20
) ();
    logic               pre_frame_vsync;
    logic               pre_frame_href;
    logic               pre_frame_clken;
    logic [CH*DW-1:0]   pre_img;
    logic [DW-1:0]      pre_tx_img;
    logic [CH*DW-1:0]   pre_A;
    logic               bypass;
    logic               post_frame_vsync;
    logic               post_frame_href;
    logic               post_frame_clken;
    logic [CH*DW-1:0]   post_img;
    logic [CW-1:0]      frame_sat_cnt;

    modport master (
        output pre_frame_vsync, pre_frame_href, pre_frame_clken,
        output pre_img, pre_tx_img, pre_A, bypass,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img, frame_sat_cnt
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_href, pre_frame_clken,
        input  pre_img, pre_tx_img, pre_A, bypass,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img, frame_sat_cnt
    );
endinterface

// File: rtl/haze_recover_pipe.sv
// Dehaze recovery: J = (I - A) / t + A per channel, evaluated as
// ((I - A) << FRAC + A*t) / t with a fully pipelined restoring divider.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : haze_recover_pipe_if.slave, pixel stream in/out plus statistics
// Latency from input to output is NW + 2 cycles for data, timing and bypass.
module haze_recover_pipe #(
    parameter int DW     = 8,
    parameter int CH     = 3,
    parameter int FRAC   = 8,
    parameter int TX_MIN = 26,
    parameter int CW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    haze_recover_pipe_if.slave bus
);
    localparam int NW  = DW + FRAC + 2;
    localparam int LAT = NW + 2;

    // Atmospheric light, latched on the input vsync rising edge.
    logic               vs_d;
    logic [CH*DW-1:0]   a_reg;

    // Stage 0 combinational numerator.
    logic [DW-1:0]      t_cur;
    logic [NW:0]        i_x, a_x, t_x, n_full, n_abs;
    logic [CH-1:0]      n_sign;
    logic [NW-1:0]      n_mag [CH];

    // Pipeline: index 0 is the stage-0 register, index j+1 the output of
    // divider stage j. Dividend/remainder/t are only needed as stage inputs.
    logic [DW-1:0]      p_t    [NW];
    logic [NW-1:0]      p_num  [NW][CH];
    logic [DW-1:0]      p_rem  [NW][CH];
    logic [NW-1:0]      p_quo  [NW+1][CH];
    logic [CH-1:0]      p_sign [NW+1];
    logic               p_byp  [NW+1];
    logic [CH*DW-1:0]   p_img  [NW+1];

    // Divider stage combinational results.
    logic [DW:0]        trial, diff;
    logic               d_bit  [NW][CH];
    logic [DW-1:0]      d_rem  [NW][CH];

    // Output stage.
    logic [NW-1:0]      q;
    logic [CH-1:0]      sat_c;
    logic [CH*DW-1:0]   out_j, out_img;
    logic               out_sat;
    logic [CH*DW-1:0]   post_img_r;
    logic               post_sat_r;
    logic [2:0]         tsr [LAT];

    // Statistics.
    logic               post_vs_d;
    logic               sat_hit;
    logic [CW-1:0]      run_cnt, sat_cnt_r;

    always_comb begin
        t_cur = (bus.pre_tx_img < DW'(TX_MIN)) ? DW'(TX_MIN) : bus.pre_tx_img;
    end

    // Numerator in NW+1-bit two's complement; the true value always fits,
    // so modular arithmetic in that width is exact.
    always_comb begin
        i_x    = '0;
        a_x    = '0;
        t_x    = '0;
        n_full = '0;
        n_abs  = '0;
        n_sign = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            i_x            = '0;
            a_x            = '0;
            t_x            = '0;
            i_x[DW-1:0]    = bus.pre_img[c*DW +: DW];
            a_x[DW-1:0]    = a_reg[c*DW +: DW];
            t_x[DW-1:0]    = t_cur;
            n_full         = ((i_x - a_x) << FRAC) + a_x * t_x;
            n_abs          = n_full[NW] ? ('0 - n_full) : n_full;
            n_sign[c]      = n_full[NW];
            n_mag[c]       = n_abs[NW-1:0];
        end
    end

    // One restoring step per stage: shift in the next dividend MSB and
    // subtract t when the partial remainder allows it.
    always_comb begin
        trial = '0;
        diff  = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            for (int unsigned c = 0; c < CH; c++) begin
                trial       = {p_rem[j][c], p_num[j][c][NW-1]};
                diff        = trial - {1'b0, p_t[j]};
                d_bit[j][c] = (trial >= {1'b0, p_t[j]});
                d_rem[j][c] = d_bit[j][c] ? diff[DW-1:0] : trial[DW-1:0];
            end
        end
    end

    always_comb begin
        q     = '0;
        sat_c = '0;
        out_j = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            q        = p_quo[NW][c];
            sat_c[c] = !p_sign[NW][c] && (q[NW-1:DW] != '0);
            if (p_sign[NW][c])
                out_j[c*DW +: DW] = '0;
            else if (sat_c[c])
                out_j[c*DW +: DW] = '1;
            else
                out_j[c*DW +: DW] = q[DW-1:0];
        end
        out_img = p_byp[NW] ? p_img[NW] : out_j;
        out_sat = !p_byp[NW] && (|sat_c);
    end

    always_comb begin
        sat_hit = bus.post_frame_clken && post_sat_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d  <= 1'b0;
            a_reg <= '0;
            for (int unsigned k = 0; k < NW; k++) begin
                p_t[k] <= '0;
                for (int unsigned c = 0; c < CH; c++) begin
                    p_num[k][c] <= '0;
                    p_rem[k][c] <= '0;
                end
            end
            for (int unsigned k = 0; k <= NW; k++) begin
                p_sign[k] <= '0;
                p_byp[k]  <= 1'b0;
                p_img[k]  <= '0;
                for (int unsigned c = 0; c < CH; c++)
                    p_quo[k][c] <= '0;
            end
            for (int unsigned k = 0; k < LAT; k++)
                tsr[k] <= '0;
            post_img_r <= '0;
            post_sat_r <= 1'b0;
            post_vs_d  <= 1'b0;
            run_cnt    <= '0;
            sat_cnt_r  <= '0;
        end else begin
            vs_d <= bus.pre_frame_vsync;
            if (bus.pre_frame_vsync && !vs_d)
                a_reg <= bus.pre_A;

            p_t[0]    <= t_cur;
            p_sign[0] <= n_sign;
            p_byp[0]  <= bus.bypass;
            p_img[0]  <= bus.pre_img;
            for (int unsigned c = 0; c < CH; c++) begin
                p_num[0][c] <= n_mag[c];
                p_rem[0][c] <= '0;
                p_quo[0][c] <= '0;
            end

            for (int unsigned j = 0; j < NW; j++) begin
                p_sign[j+1] <= p_sign[j];
                p_byp[j+1]  <= p_byp[j];
                p_img[j+1]  <= p_img[j];
                for (int unsigned c = 0; c < CH; c++)
                    p_quo[j+1][c] <= {p_quo[j][c][NW-2:0], d_bit[j][c]};
            end
            for (int unsigned j = 0; j + 1 < NW; j++) begin
                p_t[j+1] <= p_t[j];
                for (int unsigned c = 0; c < CH; c++) begin
                    p_num[j+1][c] <= p_num[j][c] << 1;
                    p_rem[j+1][c] <= d_rem[j][c];
                end
            end

            post_img_r <= out_img;
            post_sat_r <= out_sat;

            tsr[0] <= {bus.pre_frame_vsync, bus.pre_frame_href, bus.pre_frame_clken};
            for (int unsigned k = 1; k < LAT; k++)
                tsr[k] <= tsr[k-1];

            // A hit in the vsync-rise cycle already belongs to the new frame.
            post_vs_d <= bus.post_frame_vsync;
            if (bus.post_frame_vsync && !post_vs_d) begin
                sat_cnt_r <= run_cnt;
                run_cnt   <= sat_hit ? CW'(1) : '0;
            end else if (sat_hit && run_cnt != '1) begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

    assign bus.post_frame_vsync = tsr[LAT-1][2];
    assign bus.post_frame_href  = tsr[LAT-1][1];
    assign bus.post_frame_clken = tsr[LAT-1][0];
    assign bus.post_img         = post_img_r;
    assign bus.frame_sat_cnt    = sat_cnt_r;

endmodule
